// File: rtl/lfsr_prbs_gen_stream_if.sv
// Valid/ready word stream carrying PRBS output from the generator to its consumer.
interface lfsr_prbs_gen_stream_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/lfsr_prbs_gen_stream.sv
// Parallel LFSR PRBS generator with stream output, seed load, burst/continuous modes
// and single-word error injection; the combinational lfsr stepper precedes the top.
module lfsr #(
   parameter int                    LFSR_WIDTH  = 31,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
   parameter string                 LFSR_CONFIG = "FIBONACCI",
   parameter int                    REVERSE     = 0,
   parameter int                    DATA_WIDTH  = 8,
   parameter string                 STYLE       = "AUTO"
) (
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [LFSR_WIDTH-1:0] lfsr_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [LFSR_WIDTH-1:0] lfsr_out
);
   localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");

   // bits[i] is the i-th bit shifted out; the MSB of the state is the output tap
   logic [DATA_WIDTH-1:0] bits;

   function automatic logic [LFSR_WIDTH-1:0] step(input logic [LFSR_WIDTH-1:0] s,
                                                  input logic din);
      logic fb;
      fb = s[LFSR_WIDTH-1] ^ din;
      if (IS_GALOIS)
         step = {s[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
      else
         step = {s[LFSR_WIDTH-2:0], fb ^ (^(s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]))};
   endfunction

   if (STYLE == "LOOP") begin : g_loop
      always_comb begin
         logic [LFSR_WIDTH-1:0] s;
         s    = lfsr_in;
         bits = '0;
         for (int i = 0; i < DATA_WIDTH; i++) begin
            bits[i] = s[LFSR_WIDTH-1];
            s       = step(s, data_in[DATA_WIDTH-1-i]);
         end
         lfsr_out = s;
      end
   end else begin : g_unrolled
      logic [LFSR_WIDTH-1:0] chain [0:DATA_WIDTH];
      assign chain[0] = lfsr_in;
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_stage
         assign bits[gi]      = chain[gi][LFSR_WIDTH-1];
         assign chain[gi+1]   = step(chain[gi], data_in[DATA_WIDTH-1-gi]);
      end
      assign lfsr_out = chain[DATA_WIDTH];
   end

   // first generated bit lands in the MSB unless LSB-first output is requested
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_order
      if (REVERSE != 0) begin : g_lsb_first
         assign data_out[gi] = bits[gi];
      end else begin : g_msb_first
         assign data_out[DATA_WIDTH-1-gi] = bits[gi];
      end
   end
endmodule

module lfsr_prbs_gen_stream #(
   parameter int                    LFSR_WIDTH  = 31,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
   parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
   parameter string                 LFSR_CONFIG = "FIBONACCI",
   parameter int                    REVERSE     = 0,
   parameter int                    DATA_WIDTH  = 8,
   parameter string                 STYLE       = "AUTO",
   parameter int                    COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic [COUNT_WIDTH-1:0] burst_len,
   input  logic                   seed_load,
   input  logic [LFSR_WIDTH-1:0]  seed_value,
   input  logic                   inject_err,
   lfsr_prbs_gen_stream_if.master m_axis,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] word_count
);
   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} fsm_t;

   fsm_t                   fsm_reg;
   logic [LFSR_WIDTH-1:0]  state_reg;
   logic [DATA_WIDTH-1:0]  tdata_reg;
   logic                   tvalid_reg;
   logic                   done_reg;
   logic                   busy_reg;
   logic                   err_pending_reg;
   logic [COUNT_WIDTH-1:0] count_reg;
   logic [COUNT_WIDTH-1:0] remaining_reg;

   logic [LFSR_WIDTH-1:0]  seed_eff;
   logic [LFSR_WIDTH-1:0]  lfsr_in;
   logic [LFSR_WIDTH-1:0]  lfsr_out;
   logic [DATA_WIDTH-1:0]  word;
   logic [DATA_WIDTH-1:0]  flip_mask;
   logic [COUNT_WIDTH-1:0] count_inc;
   logic                   xfer;

   // a seed loaded together with start must already feed the first word
   assign seed_eff  = (seed_value == '0) ? LFSR_INIT : seed_value;
   assign lfsr_in   = (fsm_reg == IDLE && seed_load) ? seed_eff : state_reg;
   assign xfer      = tvalid_reg && m_axis.tready;
   assign flip_mask = DATA_WIDTH'(err_pending_reg | inject_err);
   assign count_inc = (count_reg == '1) ? count_reg : count_reg + COUNT_WIDTH'(1);

   lfsr #(
      .LFSR_WIDTH  (LFSR_WIDTH),
      .LFSR_POLY   (LFSR_POLY),
      .LFSR_CONFIG (LFSR_CONFIG),
      .REVERSE     (REVERSE),
      .DATA_WIDTH  (DATA_WIDTH),
      .STYLE       (STYLE)
   ) u_lfsr (
      .data_in  ({DATA_WIDTH{1'b0}}),
      .lfsr_in  (lfsr_in),
      .data_out (word),
      .lfsr_out (lfsr_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_reg         <= IDLE;
         state_reg       <= LFSR_INIT;
         tdata_reg       <= '0;
         tvalid_reg      <= 1'b0;
         done_reg        <= 1'b0;
         busy_reg        <= 1'b0;
         err_pending_reg <= 1'b0;
         count_reg       <= '0;
         remaining_reg   <= '0;
      end else begin
         done_reg <= 1'b0;
         if (inject_err)
            err_pending_reg <= 1'b1;
         case (fsm_reg)
            IDLE: begin
               if (seed_load)
                  state_reg <= seed_eff;
               if (start && !stop) begin
                  fsm_reg         <= ACTIVE;
                  busy_reg        <= 1'b1;
                  count_reg       <= '0;
                  remaining_reg   <= burst_len;
                  tdata_reg       <= word ^ flip_mask;
                  state_reg       <= lfsr_out;
                  tvalid_reg      <= 1'b1;
                  err_pending_reg <= 1'b0;
               end
            end
            ACTIVE: begin
               if (xfer) begin
                  count_reg <= count_inc;
                  // remaining stays 0 throughout a continuous run
                  if (remaining_reg != '0)
                     remaining_reg <= remaining_reg - COUNT_WIDTH'(1);
                  if (stop || remaining_reg == COUNT_WIDTH'(1)) begin
                     tvalid_reg <= 1'b0;
                     done_reg   <= 1'b1;
                     busy_reg   <= 1'b0;
                     fsm_reg    <= IDLE;
                  end else begin
                     tdata_reg       <= word ^ flip_mask;
                     state_reg       <= lfsr_out;
                     tvalid_reg      <= 1'b1;
                     err_pending_reg <= 1'b0;
                  end
               end else if (stop) begin
                  fsm_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (xfer) begin
                  count_reg  <= count_inc;
                  tvalid_reg <= 1'b0;
                  done_reg   <= 1'b1;
                  busy_reg   <= 1'b0;
                  fsm_reg    <= IDLE;
               end
            end
            default: fsm_reg <= IDLE;
         endcase
      end
   end

   assign m_axis.tdata  = tdata_reg;
   assign m_axis.tvalid = tvalid_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
   assign word_count    = count_reg;
endmodule

// File: tb/tb_lfsr_prbs_gen_stream.sv
// Scoreboard bench for lfsr_prbs_gen_stream in a PRBS7 (x^7+x^6+1) byte-wide setup.
module tb_lfsr_prbs_gen_stream;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] burst_len = '0;
   logic        seed_load = 1'b0;
   logic [6:0]  seed_value = '0;
   logic        inject_err = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] word_count;

   lfsr_prbs_gen_stream_if #(.DATA_WIDTH(8)) m_axis ();

   lfsr_prbs_gen_stream #(
      .LFSR_WIDTH  (7),
      .LFSR_POLY   (7'h41),
      .LFSR_INIT   (7'h7f),
      .LFSR_CONFIG ("FIBONACCI"),
      .REVERSE     (0),
      .DATA_WIDTH  (8),
      .STYLE       ("AUTO"),
      .COUNT_WIDTH (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .burst_len  (burst_len),
      .seed_load  (seed_load),
      .seed_value (seed_value),
      .inject_err (inject_err),
      .m_axis     (m_axis),
      .busy       (busy),
      .done       (done),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int         n_compared = 0;
   int         n_mismatched = 0;
   int         xfer_cnt = 0;
   int         done_cnt = 0;
   int         ref_idx = 0;
   bit         rec_bits = 0;
   bit         prbs [0:4095];
   logic [7:0] sb_q [$];
   bit         bit_q [$];
   bit         prev_stall = 0;
   logic [7:0] prev_tdata = '0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference stream from the recurrence b[n+7] = b[n] ^ b[n+1], seeded with seven ones
   function automatic logic [7:0] ref_word(input int k);
      logic [7:0] w;
      for (int i = 0; i < 8; i++) w[7-i] = prbs[8*k+i];
      return w;
   endfunction

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         sb_q.push_back(ref_word(ref_idx));
         ref_idx++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen = 0;
      for (int c = 0; c < budget && !seen; c++) begin
         tick();
         if (done) seen = 1;
      end
      check_value(tag, {31'd0, seen}, 32'd1);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall)
            check_value("stall_hold", {23'd0, m_axis.tvalid, m_axis.tdata}, {23'd0, 1'b1, prev_tdata});
         if (m_axis.tvalid && m_axis.tready) begin
            xfer_cnt++;
            if (rec_bits)
               for (int i = 0; i < 8; i++) bit_q.push_back(m_axis.tdata[7-i]);
            if (sb_q.size() == 0) begin
               check_value("unexpected_word", {24'd0, m_axis.tdata}, 32'hffff_ffff);
            end else begin
               logic [7:0] exp_w;
               exp_w = sb_q.pop_front();
               $display("[%0t] word %0d: tdata=%02h expected=%02h", $time, xfer_cnt, m_axis.tdata, exp_w);
               check_value("word", {24'd0, m_axis.tdata}, {24'd0, exp_w});
            end
         end
         if (done) done_cnt++;
         prev_stall = m_axis.tvalid && !m_axis.tready;
         prev_tdata = m_axis.tdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         x0, d0, viol;
      logic [7:0] held;
      bit         tpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit         seen;

      for (int n = 0; n < 7; n++) prbs[n] = 1'b1;
      for (int n = 0; n < 4096 - 7; n++) prbs[n+7] = prbs[n] ^ prbs[n+1];
      m_axis.tready = 1'b0;

      repeat (3) tick();
      rst = 1'b0;
      check_value("rst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
      check_value("rst_tdata", {24'd0, m_axis.tdata}, 32'd0);
      check_value("rst_busy", {31'd0, busy}, 32'd0);
      check_value("rst_done", {31'd0, done}, 32'd0);
      check_value("rst_word_count", word_count, 32'd0);

      // continuous run, 300 words at full rate
      x0 = xfer_cnt; d0 = done_cnt; ref_idx = 0;
      push_words(300);
      rec_bits = 1; burst_len = 0; m_axis.tready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check_value("t1_valid_latency", {31'd0, m_axis.tvalid}, 32'd1);
      check_value("t1_busy", {31'd0, busy}, 32'd1);
      repeat (299) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0; m_axis.tready = 1'b0;
      check_value("t1_done", {31'd0, done}, 32'd1);
      check_value("t1_word_count", word_count, 32'd300);
      tick();
      rec_bits = 0;
      check_value("t1_valid_off", {31'd0, m_axis.tvalid}, 32'd0);
      check_value("t1_xfers", xfer_cnt - x0, 32'd300);
      check_value("t1_done_pulses", done_cnt - d0, 32'd1);
      viol = 0;
      for (int n = 0; n + 127 < bit_q.size(); n++)
         if (bit_q[n] != bit_q[n+127]) viol++;
      check_value("t1_bits", bit_q.size(), 32'd2400);
      check_value("t1_period127", viol, 32'd0);

      // burst of 5 with tready toggling 1,0,0,1
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      sb_q.delete();
      x0 = xfer_cnt; d0 = done_cnt; ref_idx = 0;
      push_words(5);
      burst_len = 5; start = 1'b1;
      tick();
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         m_axis.tready = tpat[c % 4];
         tick();
         if (done) seen = 1;
      end
      check_value("t2_done_seen", {31'd0, seen}, 32'd1);
      check_value("t2_busy_low", {31'd0, busy}, 32'd0);
      check_value("t2_word_count", word_count, 32'd5);
      m_axis.tready = 1'b0;
      tick();
      check_value("t2_done_single", {31'd0, done}, 32'd0);
      check_value("t2_xfers", xfer_cnt - x0, 32'd5);
      check_value("t2_done_pulses", done_cnt - d0, 32'd1);

      // stop while the word is stalled: drain it, then idle
      x0 = xfer_cnt; d0 = done_cnt;
      push_words(1);
      held = ref_word(ref_idx - 1);
      burst_len = 0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick(); tick(); tick();
      check_value("t3_drain_busy", {31'd0, busy}, 32'd1);
      check_value("t3_drain_valid", {31'd0, m_axis.tvalid}, 32'd1);
      check_value("t3_drain_tdata", {24'd0, m_axis.tdata}, {24'd0, held});
      m_axis.tready = 1'b1;
      tick();
      m_axis.tready = 1'b0;
      check_value("t3_done", {31'd0, done}, 32'd1);
      check_value("t3_idle", {31'd0, busy}, 32'd0);
      tick(); tick();
      check_value("t3_no_valid", {31'd0, m_axis.tvalid}, 32'd0);
      check_value("t3_xfers", xfer_cnt - x0, 32'd1);
      check_value("t3_done_pulses", done_cnt - d0, 32'd1);

      // zero seed maps to the reset state; seed_load while busy is ignored
      seed_value = 7'd0; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      ref_idx = 0;
      push_words(4);
      burst_len = 4; m_axis.tready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; seed_value = 7'h55; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      wait_done("t4_done", 20);
      // seed and start together: first word comes from the new seed
      ref_idx = 0;
      push_words(2);
      seed_value = 7'd0; seed_load = 1'b1; burst_len = 2; start = 1'b1;
      tick();
      seed_load = 1'b0; start = 1'b0;
      wait_done("t4_seed_start_done", 20);
      // start together with stop must not leave IDLE
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check_value("t4_start_stop_busy", {31'd0, busy}, 32'd0);
      check_value("t4_start_stop_valid", {31'd0, m_axis.tvalid}, 32'd0);

      // three inject requests flip bit 0 of exactly one word
      repeat (3) begin
         inject_err = 1'b1; tick();
         inject_err = 1'b0; tick();
      end
      sb_q.push_back(ref_word(ref_idx) ^ 8'h01);
      ref_idx++;
      push_words(3);
      burst_len = 4; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t5_done", 20);

      // asynchronous reset mid-burst
      push_words(100);
      burst_len = 100; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      #2 rst = 1'b1;
      #1;
      check_value("t6_async_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
      check_value("t6_async_busy", {31'd0, busy}, 32'd0);
      check_value("t6_async_done", {31'd0, done}, 32'd0);
      check_value("t6_async_count", word_count, 32'd0);
      sb_q.delete();
      tick(); tick();
      rst = 1'b0;
      d0 = done_cnt;
      ref_idx = 0;
      push_words(6);
      burst_len = 6; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t6_done", 20);
      check_value("t6_word_count", word_count, 32'd6);
      m_axis.tready = 1'b0;
      tick();
      check_value("t6_done_pulses", done_cnt - d0, 32'd1);
      check_value("scoreboard_empty", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
